// File: rtl/clock_divider_pkg.sv
// Shared types and helpers for the divided-clock controller and its period counter.
package clock_divider_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t RUN    = 2'd1;
    localparam state_t SWITCH = 2'd2;

    function automatic int sel_width(input int num_stages);
        return $clog2(num_stages + 1);
    endfunction

    function automatic bit sel_in_range(input int sel, input int num_stages);
        return (sel >= 1) && (sel <= num_stages);
    endfunction

endpackage

// File: rtl/clock_divider_controller_period_counter.sv
// Period counter: counts 0..2^sel-1 while running, flags the last cycle and
// provides the counter bit that forms the 50% divided clock.
module divider_period_counter
    import clock_divider_pkg::*;
#(
    parameter int NUM_STAGES = 7,
    localparam int SEL_W = sel_width(NUM_STAGES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [SEL_W-1:0] sel,
    output logic             terminal,
    output logic             div_bit
);

    localparam logic [NUM_STAGES-1:0] ONE = {{(NUM_STAGES-1){1'b0}}, 1'b1};

    logic [NUM_STAGES-1:0] cnt;
    logic [NUM_STAGES-1:0] top_bit;
    logic [NUM_STAGES-1:0] wrap_mask;

    // top_bit is the weight of bit sel-1; OR-ing in everything below it gives
    // 2^sel-1 without needing a wider intermediate when sel == NUM_STAGES.
    assign top_bit   = ONE << (sel - 1'b1);
    assign wrap_mask = top_bit | (top_bit - 1'b1);
    assign terminal  = (cnt == wrap_mask);
    assign div_bit   = |(cnt & top_bit);

    always_ff @(posedge clk) begin
        if (!rst || !run) begin
            cnt <= '0;
        end else if (terminal) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clock_divider_controller.sv
// Divided-clock generator with run-time ratio control; ratio and stop requests
// only take effect at a period boundary so no runt or stretched phase appears.
module clock_divider_controller
    import clock_divider_pkg::*;
#(
    parameter int NUM_STAGES = 7,
    parameter int RESET_SEL  = 1,
    localparam int SEL_W = sel_width(NUM_STAGES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [SEL_W-1:0] cfg_sel,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [SEL_W-1:0] cur_sel,
    output logic             clk_div,
    output logic             tick,
    output logic             running
);

    if (!sel_in_range(RESET_SEL, NUM_STAGES)) begin : g_bad_reset_sel
        $error("RESET_SEL must be within 1..NUM_STAGES");
    end

    state_t           state;
    logic [SEL_W-1:0] pending;
    logic             accept;
    logic             sel_ok;
    logic             take;
    logic             terminal;
    logic             div_bit;

    // cfg transfers on cfg_valid & cfg_ready; ready drops only while a ratio
    // is parked waiting for the boundary.
    assign cfg_ready = (state != SWITCH);
    assign running   = (state != IDLE);
    assign accept    = cfg_valid & cfg_ready;
    assign sel_ok    = sel_in_range(int'(cfg_sel), NUM_STAGES);
    assign take      = accept & sel_ok;
    assign tick      = running & terminal;
    assign clk_div   = running & div_bit;

    divider_period_counter #(
        .NUM_STAGES (NUM_STAGES)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .run      (running),
        .sel      (cur_sel),
        .terminal (terminal),
        .div_bit  (div_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cur_sel <= SEL_W'(RESET_SEL);
            pending <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= accept & ~sel_ok;
            case (state)
                IDLE: begin
                    if (take) cur_sel <= cfg_sel;
                    if (enable) state <= RUN;
                end
                RUN: begin
                    if (tick) begin
                        if (take) cur_sel <= cfg_sel;
                        if (!enable) state <= IDLE;
                    end else if (take) begin
                        pending <= cfg_sel;
                        state   <= SWITCH;
                    end
                end
                SWITCH: begin
                    if (tick) begin
                        cur_sel <= pending;
                        state   <= enable ? RUN : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_divider_controller.sv
// Bench for clock_divider_controller: directed scenarios then random traffic,
// every cycle compared against a period-position reference model.
module tb_clock_divider_controller;

    localparam int NS = 7;
    localparam int RS = 1;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          cfg_valid;
    logic [SW-1:0] cfg_sel;
    logic          cfg_ready;
    logic          cfg_err;
    logic [SW-1:0] cur_sel;
    logic          clk_div;
    logic          tick;
    logic          running;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: position within the current period, ratio, queued ratio.
    bit m_run;
    int m_pos;
    int m_sel;
    int m_pend;
    bit m_err;

    clock_divider_controller #(
        .NUM_STAGES (NS),
        .RESET_SEL  (RS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_sel   (cfg_sel),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .cur_sel   (cur_sel),
        .clk_div   (clk_div),
        .tick      (tick),
        .running   (running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit v, input int s);
        bit acc;
        bit ok;
        int per;
        if (!r) begin
            m_run = 0; m_pos = 0; m_sel = RS; m_pend = 0; m_err = 0;
            return;
        end
        acc   = v && (m_pend == 0);
        ok    = (s >= 1) && (s <= NS);
        m_err = acc && !ok;
        per   = 1 << m_sel;
        if (!m_run) begin
            if (acc && ok) m_sel = s;
            if (e) begin
                m_run = 1;
                m_pos = 0;
            end
        end else if (m_pos == per - 1) begin
            if (m_pend != 0) m_sel = m_pend;
            else if (acc && ok) m_sel = s;
            m_pend = 0;
            m_pos  = 0;
            m_run  = e;
        end else begin
            m_pos++;
            if (acc && ok) m_pend = s;
        end
    endtask

    task automatic cycle(input bit r, input bit e, input bit v, input int s);
        @(negedge clk);
        chk("running", 32'(running), 32'(m_run));
        chk("cur_sel", 32'(cur_sel), 32'(m_sel));
        chk("clk_div", 32'(clk_div), 32'(m_run && (m_pos >= (1 << (m_sel - 1)))));
        chk("tick", 32'(tick), 32'(m_run && (m_pos == (1 << m_sel) - 1)));
        chk("cfg_ready", 32'(cfg_ready), 32'(m_pend == 0));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
        rst       = r;
        enable    = e;
        cfg_valid = v;
        cfg_sel   = SW'(s);
        @(posedge clk);
        model_step(r, e, v, s);
    endtask

    task automatic run_cycles(input int n, input bit e);
        for (int k = 0; k < n; k++) cycle(1, e, 0, 0);
    endtask

    task automatic wait_pos(input int p, input int sl);
        for (int k = 0; k < 400 && !(m_run && m_pos == p && m_sel == sl); k++)
            cycle(1, 1, 0, 0);
        if (!(m_run && m_pos == p && m_sel == sl)) begin
            miscompares++;
            $error("FAIL sync pos=%0d sel=%0d wanted pos=%0d sel=%0d", m_pos, m_sel, p, sl);
        end
    endtask

    initial begin
        bit r;
        bit e;
        bit v;
        int s;

        rst = 1'b0; enable = 1'b0; cfg_valid = 1'b0; cfg_sel = '0;
        model_step(0, 0, 0, 0);
        repeat (2) @(posedge clk);

        // Reset state, then start at sel=1.
        cycle(0, 0, 0, 0);
        cycle(1, 1, 0, 0);
        run_cycles(6, 1);

        // Ratio change mid-period parks in SWITCH until the boundary.
        wait_pos(0, 1);
        cycle(1, 1, 1, 3);
        run_cycles(20, 1);

        // Out-of-range requests pulse cfg_err and change nothing.
        cycle(1, 1, 1, 0);
        run_cycles(2, 1);
        cycle(1, 1, 1, 8);
        run_cycles(10, 1);

        // sel=2, stop requested at cnt=1, then restart.
        wait_pos(0, 3);
        cycle(1, 1, 1, 2);
        wait_pos(1, 2);
        cycle(1, 0, 0, 0);
        run_cycles(4, 0);
        run_cycles(8, 1);

        // Ratio accepted on the boundary cycle takes effect immediately.
        wait_pos(3, 2);
        cycle(1, 1, 1, 5);
        run_cycles(40, 1);

        // Reset while a ratio is pending discards it.
        wait_pos(0, 5);
        cycle(1, 1, 1, 6);
        run_cycles(3, 1);
        cycle(0, 1, 0, 0);
        run_cycles(6, 1);

        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 299) != 0);
            e = ($urandom_range(0, 15) != 0);
            v = ($urandom_range(0, 5) == 0);
            s = int'($urandom_range(0, 7));
            cycle(r, e, v, s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
